educ8_cycle_sequencer: RTL
==========================

Name: educ8_cycle_sequencer

Overview:
Major-state and time-pulse controller for the EDUC-8 processor. It generates the one-hot timing pulses T0..T(N-1) that strobe the datapath registers and counters. It sequences the FETCH/DEFER/EXEC major cycles and implements front-panel RUN, STOP, single-step and CONTINUE, plus halt on the HLT instruction. It sits between the front-panel switch logic and the instruction decoder/datapath.

Parameters:
TSTATES, 8, time states per major cycle; legal range 2..8.
TW, 3, width of tcount; must satisfy 2**TW >= TSTATES.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
nclr  in  1  asynchronous, active-low reset.
run_req  in  1  front-panel RUN; the rising edge is used.
halt_req  in  1  front-panel STOP; level, latched internally.
sstep  in  1  single-step mode select; level.
cont  in  1  front-panel CONTINUE; the rising edge is used.
hlt_instr  in  1  decoded HLT; sampled only at cyc_end.
need_defer  in  1  indirect bit; sampled at cyc_end of FETCH.
need_exec  in  1  instruction needs an EXEC cycle; sampled at cyc_end of FETCH.
run  out  1  machine running.
major  out  2  current or next major state: 0=FETCH, 1=DEFER, 2=EXEC. Code 3 is never produced.
tcount  out  TW  current time state.
tstate  out  TSTATES  one-hot time pulse.
cyc_end  out  1  last time state of the current major cycle.

Behaviour:
- Reset (nclr=0, asynchronous) forces the following, immediately and mid-cycle if necessary:
  - run=0, tcount=0, major=FETCH, halt_pending=0.
  - tstate=0, cyc_end=0.
  - Edge-detector history registers forced to 1, so a RUN or CONT held through reset does not start the machine; the input must drop and rise again.
- Edge detect: rise = in & ~prev; prev <= in on every clk.
- tstate = run ? (1 << tcount) : 0. cyc_end = run & (tcount == TSTATES-1). Both are decoded combinationally from registers.
- Halted (run=0):
  - run_req rise: run<=1, tcount<=0, major<=FETCH, halt_pending<=0. T0 is asserted in the cycle after that edge.
  - cont rise without run_req rise: run<=1, tcount<=0, major unchanged. run_req takes priority if both rise together.
  - tcount holds at 0.
- Running: tcount increments each clk. At cyc_end it wraps to 0 and major advances:
  - FETCH -> DEFER if need_defer; else EXEC if need_exec; else FETCH.
  - DEFER -> EXEC always.
  - EXEC -> FETCH always.
  - Forced next state: hlt_instr=1 at cyc_end forces next major=FETCH.
- Stop rules, evaluated at cyc_end; run<=0 at that edge, with major loaded with the next state:
  - hlt_instr=1: stop, next=FETCH.
  - halt_pending=1 and computed next==FETCH: stop at the instruction boundary. halt_pending clears.
  - sstep=1: stop after every major cycle; major holds the next state so CONT resumes correctly.
- halt_pending is set by halt_req=1 on any clk while running. It is cleared on the stop edge and on run_req start.
- halt_req=1 while halted: run_req and cont are ignored; STOP dominates.
- cont or run_req edges while running are ignored.
- Latency: RUN edge to T0 is 1 clk. The last T pulse to run=0 occurs on the same edge.

Decomposition:
- Shared package educ8_pkg: constants MAJ_FETCH=2'd0, MAJ_DEFER=2'd1, MAJ_EXEC=2'd2, and default TSTATES=8.
- Sub-module educ8_edge_det (clk, nclr, in, rise), with the history register resetting to 1. Instantiated twice, for run_req and cont.

Test Plan:
1. Reset, then pulse run_req with need_defer=need_exec=0.
   -> run=1 one clk later; tstate 0x01,0x02,…,0x80 with cyc_end on 0x80; then 0x01 again with major=0 throughout.
2. Running, need_defer=1 at FETCH cyc_end.
   -> major=1 for 8 clks, then major=2 for 8 clks, then major=0; tcount wraps 7->0 at each boundary.
3. halt_req pulsed 1 clk at T2 of FETCH, need_exec=1.
   -> FETCH completes, EXEC runs all 8 T states, then run=0, tstate=0x00, major=0. No stop occurs at the FETCH->EXEC boundary.
4. sstep=1, then run_req; FETCH with need_exec=1.
   -> after 8 T pulses run=0 with major=2. A cont rise runs exactly one EXEC cycle, then halts with major=0.
5. run_req held 1 while nclr is released.
   -> run stays 0. Drop run_req, then raise it -> run=1 on the next edge.
6. nclr asserted at T4 of EXEC with halt_pending=1.
   -> immediately run=0, tcount=0, tstate=0, major=0. After release plus a RUN edge, the machine runs past FETCH cyc_end without halting (pending cleared).

Source files
------------

// File: rtl/educ8_pkg.sv
// Shared constants and major-cycle encoding for the EDUC-8 control path.
// The major-state successor function lives here so the decoder can reuse it.
package educ8_pkg;

    localparam int DEFAULT_TSTATES = 8;

    typedef enum logic [1:0] {
        MAJ_FETCH = 2'd0,
        MAJ_DEFER = 2'd1,
        MAJ_EXEC  = 2'd2
    } major_t;

    // Successor of a major cycle; HLT always returns to FETCH.
    function automatic major_t next_major(
        input major_t cur,
        input logic   need_defer,
        input logic   need_exec,
        input logic   hlt_instr
    );
        major_t nxt;
        case (cur)
            MAJ_FETCH: nxt = need_defer ? MAJ_DEFER : (need_exec ? MAJ_EXEC : MAJ_FETCH);
            MAJ_DEFER: nxt = MAJ_EXEC;
            default:   nxt = MAJ_FETCH;
        endcase
        if (hlt_instr) begin
            nxt = MAJ_FETCH;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/educ8_edge_det.sv
// Rising-edge detector for front-panel switches. History resets to 1 so a
// switch held through reset must be released and pressed again.
module educ8_edge_det (
    input  logic clk,
    input  logic nclr,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            prev <= 1'b1;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/educ8_cycle_sequencer.sv
// Major-cycle and time-pulse sequencer: FETCH/DEFER/EXEC with one-hot T pulses,
// front-panel RUN/STOP/CONTINUE, single-step and HLT handling.
module educ8_cycle_sequencer
    import educ8_pkg::*;
#(
    parameter int TSTATES = DEFAULT_TSTATES,
    parameter int TW      = 3
) (
    input  logic               clk,
    input  logic               nclr,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               sstep,
    input  logic               cont,
    input  logic               hlt_instr,
    input  logic               need_defer,
    input  logic               need_exec,
    output logic               run,
    output logic [1:0]         major,
    output logic [TW-1:0]      tcount,
    output logic [TSTATES-1:0] tstate,
    output logic               cyc_end
);

    logic          run_q, run_n;
    logic [TW-1:0] tcount_q, tcount_n;
    major_t        major_q, major_n;
    logic          halt_pending_q, halt_pending_n;

    logic   run_rise;
    logic   cont_rise;
    major_t next_maj;
    logic   stop;

    educ8_edge_det u_run_edge (
        .clk  (clk),
        .nclr (nclr),
        .in   (run_req),
        .rise (run_rise)
    );

    educ8_edge_det u_cont_edge (
        .clk  (clk),
        .nclr (nclr),
        .in   (cont),
        .rise (cont_rise)
    );

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            run_q          <= 1'b0;
            tcount_q       <= '0;
            major_q        <= MAJ_FETCH;
            halt_pending_q <= 1'b0;
        end else begin
            run_q          <= run_n;
            tcount_q       <= tcount_n;
            major_q        <= major_n;
            halt_pending_q <= halt_pending_n;
        end
    end

    assign cyc_end  = run_q & (tcount_q == TW'(TSTATES - 1));
    assign next_maj = next_major(major_q, need_defer, need_exec, hlt_instr);
    // A pending STOP only takes effect at an instruction boundary (next is FETCH).
    assign stop     = hlt_instr | sstep | (halt_pending_q & (next_maj == MAJ_FETCH));

    always_comb begin
        run_n          = run_q;
        tcount_n       = tcount_q;
        major_n        = major_q;
        halt_pending_n = halt_pending_q;

        if (!run_q) begin
            tcount_n = '0;
            // STOP held down dominates both start buttons.
            if (!halt_req) begin
                if (run_rise) begin
                    run_n          = 1'b1;
                    major_n        = MAJ_FETCH;
                    halt_pending_n = 1'b0;
                end else if (cont_rise) begin
                    run_n = 1'b1;
                end
            end
        end else begin
            if (halt_req) begin
                halt_pending_n = 1'b1;
            end
            if (cyc_end) begin
                tcount_n = '0;
                major_n  = next_maj;
                if (stop) begin
                    run_n          = 1'b0;
                    halt_pending_n = 1'b0;
                end
            end else begin
                tcount_n = tcount_q + TW'(1);
            end
        end
    end

    assign run    = run_q;
    assign major  = major_q;
    assign tcount = tcount_q;
    assign tstate = run_q ? (TSTATES'(1) << tcount_q) : '0;

endmodule
